// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture slice: sample width, default RAM
// address width and the capture state encoding.
package scope_pkg;

    localparam int unsigned ADC_DW     = 8;
    localparam int unsigned AW_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } cap_state_t;

    // Status outputs {busy, done, n_oe} that belong to a given state.
    function automatic logic [2:0] status_of(cap_state_t s);
        logic busy;
        busy = (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
        return {busy, (s == ST_DONE), ~busy};
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample-RAM write port of the capture controller; master side is the
// controller, slave side the RAM.
interface adc_capture_ctrl_if #(
    parameter int unsigned AW = scope_pkg::AW_DEFAULT
);
    import scope_pkg::*;

    logic              WR_EN;
    logic [AW-1:0]     WR_ADDR;
    logic [ADC_DW-1:0] WR_DATA;

    modport master (output WR_EN, WR_ADDR, WR_DATA);
    modport slave  (input  WR_EN, WR_ADDR, WR_DATA);

endinterface

// File: rtl/adc_clk_gen.sv
// Free-running converter clock divider; strobe marks the first CLK cycle of
// each ADC_CLK high phase.
module adc_clk_gen #(
    parameter int unsigned DIV_HALF = 2
) (
    input  logic CLK,
    input  logic nRST,
    output logic ADC_CLK,
    output logic strobe
);

    localparam logic [7:0] LAST = 8'(DIV_HALF - 1);

    logic [7:0] div_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_cnt <= '0;
            ADC_CLK <= 1'b0;
            strobe  <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            ADC_CLK <= ~ADC_CLK;
            strobe  <= ~ADC_CLK;
        end else begin
            div_cnt <= div_cnt + 8'd1;
            strobe  <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger ADC capture into a circular sample RAM.
// Optional macro ADC_CAPTURE_FORCE_TRIG_EN adds the FORCE_TRIG input.
module adc_capture_ctrl
    import scope_pkg::*;
#(
    parameter int unsigned DIV_HALF = 2,
    parameter int unsigned AW       = AW_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ARM,
    input  logic              ABORT,
    input  logic [ADC_DW-1:0] TRIG_LEVEL,
    input  logic              TRIG_RISING,
    input  logic [AW-1:0]     PRE_CNT,
    input  logic [ADC_DW-1:0] ADC_D,
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
    input  logic              FORCE_TRIG,
`endif
    output logic              ADC_CLK,
    output logic              ADC_nOE,
    adc_capture_ctrl_if.master wr,
    output logic [AW-1:0]     TRIG_ADDR,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic              strobe;
    cap_state_t        state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     pre_lat;
    logic [AW-1:0]     post_len;
    logic [AW-1:0]     phase_cnt;
    logic [ADC_DW-1:0] prev;
    logic              first;
    logic              rise_hit;
    logic              fall_hit;
    logic              level_hit;
    logic              trig_hit;
    logic              do_write;
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
    logic              force_pend;
`endif

    adc_clk_gen #(.DIV_HALF(DIV_HALF)) u_clk_gen (
        .CLK     (CLK),
        .nRST    (nRST),
        .ADC_CLK (ADC_CLK),
        .strobe  (strobe)
    );

    // Post-trigger writes beyond the trigger sample: DEPTH-1-pre = ~pre in AW bits.
    always_comb begin
        post_len  = ~pre_lat;
        rise_hit  = (prev < TRIG_LEVEL) && (TRIG_LEVEL <= ADC_D);
        fall_hit  = (prev >= TRIG_LEVEL) && (TRIG_LEVEL > ADC_D);
        level_hit = !first && (TRIG_RISING ? rise_hit : fall_hit);
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
        trig_hit  = level_hit || force_pend || FORCE_TRIG;
`else
        trig_hit  = level_hit;
`endif
        do_write  = strobe && ((state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state                  <= ST_IDLE;
            {BUSY, DONE, ADC_nOE}  <= status_of(ST_IDLE);
            wr.WR_EN               <= 1'b0;
            wr.WR_ADDR             <= '0;
            wr.WR_DATA             <= '0;
            TRIG_ADDR              <= '0;
            wr_ptr                 <= '0;
            pre_lat                <= '0;
            phase_cnt              <= '0;
            prev                   <= '0;
            first                  <= 1'b1;
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
            force_pend             <= 1'b0;
`endif
        end else if (ABORT) begin
            state                  <= ST_IDLE;
            {BUSY, DONE, ADC_nOE}  <= status_of(ST_IDLE);
            wr.WR_EN               <= 1'b0;
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
            force_pend             <= 1'b0;
`endif
        end else begin
            wr.WR_EN <= do_write;
            if (do_write) begin
                wr.WR_ADDR <= wr_ptr;
                wr.WR_DATA <= ADC_D;
                wr_ptr     <= wr_ptr + ONE;
                prev       <= ADC_D;
                first      <= 1'b0;
            end
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
            if ((state == ST_WAIT) && FORCE_TRIG) force_pend <= 1'b1;
`endif
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (ARM) begin
                        wr_ptr    <= '0;
                        phase_cnt <= '0;
                        pre_lat   <= PRE_CNT;
                        first     <= 1'b1;
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
                        force_pend <= 1'b0;
`endif
                        if (PRE_CNT == '0) begin
                            state                 <= ST_WAIT;
                            {BUSY, DONE, ADC_nOE} <= status_of(ST_WAIT);
                        end else begin
                            state                 <= ST_PRE;
                            {BUSY, DONE, ADC_nOE} <= status_of(ST_PRE);
                        end
                    end
                end
                ST_PRE: begin
                    if (do_write) begin
                        if (phase_cnt == pre_lat - ONE) begin
                            state                 <= ST_WAIT;
                            {BUSY, DONE, ADC_nOE} <= status_of(ST_WAIT);
                            phase_cnt             <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (do_write && trig_hit) begin
                        TRIG_ADDR <= wr_ptr;
                        phase_cnt <= '0;
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
                        force_pend <= 1'b0;
`endif
                        if (post_len == '0) begin
                            state                 <= ST_DONE;
                            {BUSY, DONE, ADC_nOE} <= status_of(ST_DONE);
                        end else begin
                            state                 <= ST_POST;
                            {BUSY, DONE, ADC_nOE} <= status_of(ST_POST);
                        end
                    end
                end
                ST_POST: begin
                    if (do_write) begin
                        if (phase_cnt == post_len - ONE) begin
                            state                 <= ST_DONE;
                            {BUSY, DONE, ADC_nOE} <= status_of(ST_DONE);
                        end else begin
                            phase_cnt <= phase_cnt + ONE;
                        end
                    end
                end
                default: begin
                    state                 <= ST_IDLE;
                    {BUSY, DONE, ADC_nOE} <= status_of(ST_IDLE);
                end
            endcase
        end
    end

endmodule
